// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
// Round-robin frame sequencer for an MCP3201-class 12-bit serial ADC shared by
// two requesters. Drives CS/P3 for one conversion frame, shifts in the result
// from P4 MSB first and returns it tagged with the requester id.
// Optional feature macro: ADC_AUTO_TRIGGER_EN adds a periodic, lowest-priority
// auto-trigger requester (id 2).
module adc_frame_scheduler #(
    parameter int unsigned HALF_DIV    = 500,
    parameter int unsigned FRAME_BITS  = 15,
    parameter int unsigned SKIP_BITS   = 3,
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned CS_IDLE     = 50
`ifdef ADC_AUTO_TRIGGER_EN
    ,parameter int unsigned AUTO_PERIOD = 50000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           id,
    output logic [DATA_BITS-1:0] data,
    output logic                 CS,
    output logic                 P3,
    input  logic                 P4
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int unsigned HC_W = $clog2(HALF_DIV + 1);
    localparam int unsigned BC_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned IC_W = $clog2(CS_IDLE + 1);

    localparam logic [HC_W-1:0] HALF_LAST  = HC_W'(HALF_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0] BIT_FIRST  = BC_W'(SKIP_BITS);
    localparam logic [IC_W-1:0] IDLE_LAST  = IC_W'(CS_IDLE - 1);

    logic [1:0]           r_state;
    logic [HC_W-1:0]      r_hcnt;
    logic [BC_W-1:0]      r_bcnt;
    logic [IC_W-1:0]      r_icnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic [1:0]           r_id;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_cs;
    logic                 r_p3;
    logic                 r_rr;

    logic                 w_grant_any;
    logic [1:0]           w_grant_id;

`ifdef ADC_AUTO_TRIGGER_EN
    localparam int unsigned TM_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [TM_W-1:0] TIMER_LAST = TM_W'(AUTO_PERIOD - 1);

    logic [TM_W-1:0] r_timer;
    logic            r_auto_pend;
    logic            w_auto_grant;
`endif

    // Arbitration: round-robin between req[1:0]; auto request only when req is idle
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = 2'd0;
        if (req == 2'b11) begin
            w_grant_any = 1'b1;
            w_grant_id  = r_rr ? 2'd1 : 2'd0;
        end else if (req[0]) begin
            w_grant_any = 1'b1;
            w_grant_id  = 2'd0;
        end else if (req[1]) begin
            w_grant_any = 1'b1;
            w_grant_id  = 2'd1;
`ifdef ADC_AUTO_TRIGGER_EN
        end else if (r_auto_pend) begin
            w_grant_any = 1'b1;
            w_grant_id  = 2'd2;
`endif
        end
    end

`ifdef ADC_AUTO_TRIGGER_EN
    assign w_auto_grant = (r_state == S_IDLE) && w_grant_any && (w_grant_id == 2'd2);

    // Free-running auto-trigger timer; expiries while pending collapse into one request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_auto_pend <= 1'b0;
        end else begin
            if (r_timer == TIMER_LAST) begin
                r_timer     <= '0;
                r_auto_pend <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (w_auto_grant) begin
                    r_auto_pend <= 1'b0;
                end
            end
        end
    end
`endif

    // Frame sequencer: grant, CS setup, P3 bit clocking with P4 capture, CS idle hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_icnt  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_id    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
            r_p3    <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_id    <= w_grant_id;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_hcnt  <= '0;
                        r_state <= S_SETUP;
                        if (w_grant_id != 2'd2) begin
                            r_rr <= ~w_grant_id[0];
                        end
                    end
                end
                S_SETUP: begin
                    if (r_hcnt == HALF_LAST) begin
                        r_hcnt  <= '0;
                        r_bcnt  <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_hcnt == HALF_LAST) begin
                        r_hcnt <= '0;
                        if (!r_p3) begin
                            // Rising P3 edge: capture P4 unless still in the skip window
                            r_p3 <= 1'b1;
                            if (r_bcnt >= BIT_FIRST) begin
                                r_shift <= {r_shift[DATA_BITS-2:0], P4};
                            end
                        end else begin
                            r_p3 <= 1'b0;
                            if (r_bcnt == BIT_LAST) begin
                                r_cs    <= 1'b1;
                                r_data  <= r_shift;
                                r_done  <= 1'b1;
                                r_icnt  <= '0;
                                r_state <= S_HOLD;
                            end else begin
                                r_bcnt <= r_bcnt + 1'b1;
                            end
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    r_bcnt <= '0;
                    if (r_icnt == IDLE_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign id   = r_id;
    assign data = r_data;
    assign CS   = r_cs;
    assign P3   = r_p3;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Testbench for adc_frame_scheduler: behavioural ADC pin model plus a
// scoreboard of expected {id, data, done time} per frame.
module tb_adc_frame_scheduler;

    localparam int unsigned HALF_DIV   = 2;
    localparam int unsigned FRAME_BITS = 15;
    localparam int unsigned SKIP_BITS  = 3;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned CS_IDLE    = 4;
    // Edges from the granting edge to the edge that first samples done high
    localparam int unsigned LAT = 1 + HALF_DIV + 2 * HALF_DIV * FRAME_BITS;
`ifdef ADC_AUTO_TRIGGER_EN
    localparam int unsigned AUTO_PERIOD = 200;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req = 2'b00;
    logic                 busy;
    logic                 done;
    logic [1:0]           id;
    logic [DATA_BITS-1:0] data;
    logic                 CS;
    logic                 P3;
    logic                 P4 = 1'b0;

    adc_frame_scheduler #(
        .HALF_DIV  (HALF_DIV),
        .FRAME_BITS(FRAME_BITS),
        .SKIP_BITS (SKIP_BITS),
        .DATA_BITS (DATA_BITS),
        .CS_IDLE   (CS_IDLE)
`ifdef ADC_AUTO_TRIGGER_EN
        ,.AUTO_PERIOD(AUTO_PERIOD)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .busy(busy),
        .done(done),
        .id  (id),
        .data(data),
        .CS  (CS),
        .P3  (P3),
        .P4  (P4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int done_cyc;
        int grant_cyc;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int ptr = 0;
    int mode = 0;
    int last_done_id = -1;
    int last_done_grant = 0;
    int gap_valid = 0;

    logic [1:0] req_q = 2'b00;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_q <= req;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC pin model and expectation generator
    logic                 cs_d = 1'b1;
    logic                 p3_d = 1'b0;
    logic [FRAME_BITS-1:0] bits = '0;
    logic [DATA_BITS-1:0] word = '0;
    logic [SKIP_BITS-1:0] junk = '0;
    int k = 0;
    int p3_pulses = 0;
    int p3_bad = 0;
    int cs_high_cnt = 0;

    always @(negedge clk) begin
        if (cs_d && !CS) begin
            word = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
            junk = SKIP_BITS'($urandom_range(0, (1 << SKIP_BITS) - 1));
            case (mode)
                1: begin word = '1; junk = '0; end
                2: begin word = '0; junk = '1; end
                3: word = 12'hA5C;
                default: ;
            endcase
            bits = {junk, word};
            k = 1;
            P4 = bits[FRAME_BITS - k];
            begin
                exp_t e;
                int eid;
                if (req_q == 2'b11) eid = ptr;
                else if (req_q[0]) eid = 0;
                else if (req_q[1]) eid = 1;
`ifdef ADC_AUTO_TRIGGER_EN
                else eid = 2;
`else
                else eid = 3;
`endif
                if (eid < 2) ptr = 1 - eid;
                e.id        = eid;
                e.data      = int'(word);
                e.done_cyc  = cyc + int'(LAT) - 1;
                e.grant_cyc = cyc;
                sbq.push_back(e);
            end
            if (gap_valid != 0) chk("cs_gap_min", int'(cs_high_cnt >= int'(CS_IDLE)), 1);
            p3_pulses = 0;
            p3_bad    = 0;
        end else if (!CS && p3_d && !P3) begin
            k++;
            if (k <= int'(FRAME_BITS)) P4 = bits[FRAME_BITS - k];
        end
        if (!CS && !p3_d && P3) p3_pulses++;
        if (CS && P3) p3_bad++;
        if (CS) cs_high_cnt++;
        else cs_high_cnt = 0;
        cs_d = CS;
        p3_d = P3;
    end

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            frames++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("id", int'(id), e.id);
                chk("data", int'(data), e.data);
                chk("done_latency", cyc, e.done_cyc);
                chk("p3_pulses", p3_pulses, int'(FRAME_BITS));
                chk("p3_toggle_cs_high", p3_bad, 0);
                last_done_grant = e.grant_cyc;
            end
            last_done_id = int'(id);
            gap_valid = 1;
        end
    end

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rst_cs", int'(CS), 1);
            chk("rst_p3", int'(P3), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
        end
        chk("rst_id", int'(id), 0);
        chk("rst_data", int'(data), 0);
        rst = 1'b0;
        sbq.delete();
        ptr = 0;
        gap_valid = 0;
    endtask

    task automatic wait_frames(input int n, input string what);
        int target;
        int budget;
        target = frames + n;
        budget = n * 300 + 300;
        while (frames < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({"timeout_", what}, int'(frames >= target), 1);
    endtask

    task automatic wait_busy(input string what);
        int budget;
        budget = 500;
        while (!busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({"busy_", what}, int'(busy), 1);
    endtask

    initial begin
        do_reset(3);

        mode = 3; req = 2'b01;
        wait_frames(1, "a5c");
        req = 2'b00;

        mode = 1; req = 2'b01;
        wait_frames(1, "ones");
        req = 2'b00;
        mode = 2; req = 2'b10;
        wait_frames(1, "zeros");
        req = 2'b00;

        // Abort a frame in the middle of the shift phase
        mode = 0; req = 2'b01;
        wait_busy("midreset");
        repeat (20) @(negedge clk);
        req = 2'b00;
        do_reset(3);
        repeat (6) @(negedge clk);
        chk("post_reset_idle_busy", int'(busy), 0);
        chk("post_reset_idle_cs", int'(CS), 1);

        req = 2'b11;
        wait_frames(4, "alternate");
        req = 2'b00;

        // req[1] raised while req[0] is being served
        req = 2'b01;
        wait_busy("late_req1");
        repeat (10) @(negedge clk);
        req = 2'b11;
        wait_frames(1, "late_first");
        req = 2'b10;
        wait_frames(1, "late_second");
        req = 2'b00;

        for (int n = 0; n < 8; n++) begin
            mode = int'($urandom_range(0, 3));
            req  = 2'($urandom_range(1, 3));
            wait_frames(1, "random");
            if ($urandom_range(0, 1) == 1) req = 2'b00;
        end
        req = 2'b00;

`ifdef ADC_AUTO_TRIGGER_EN
        begin
            int g3;
            int g4;
            mode = 0;
            wait_frames(3, "auto_settle");
            g3 = last_done_grant;
            wait_frames(1, "auto_period");
            g4 = last_done_grant;
            chk("auto_id", last_done_id, 2);
            chk("auto_interval", g4 - g3, int'(AUTO_PERIOD));
            while (cyc < g4 + 150) @(negedge clk);
            req = 2'b01;
            wait_frames(1, "auto_req0_a");
            wait_frames(1, "auto_req0_b");
            chk("req0_beats_auto", last_done_id, 0);
            req = 2'b00;
            wait_frames(1, "auto_after");
            chk("auto_after_req0", last_done_id, 2);
        end
`else
        begin
            int f0;
            f0 = frames;
            repeat (300) @(negedge clk);
            chk("no_frame_without_req", frames, f0);
            chk("cs_idle_without_req", int'(CS), 1);
        end
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
